alu_input_ctrl: RTL

Input stage for the 4-bit ALU board design. It synchronizes and debounces the three push buttons, and captures the 4-bit switch value into operand A, operand B or the operation select. It then issues a complete operation to the ALU through a valid/ready handshake. This replaces raw button sampling, so each physical press produces exactly one load and each operation is presented atomically.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 63 ++++++
 rtl/alu_input_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared select encodings, operand width and types for the ALU board input stage.
package alu_pkg;

    localparam int unsigned OPND_W = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        alu_sel_e          sel;
    } alu_op_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, debounce counter and registered rising-edge pulse for one button.
// ALU_IN_DEBOUNCE_EN selects the counter; without it the level follows the synchronizer directly.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press,
    output logic level
);

    logic [1:0] sync;
    logic       level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], raw};
        end
    end

    // Configurations the counter cannot represent elaborate nothing extra here.
    if (CNT_W < 1 || DEBOUNCE_CYCLES < 2) begin : g_cfg_illegal
    end

`ifdef ALU_IN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreements; flipping on the last one also clears the
    // count, so it never passes CNT_LAST and cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync[1];
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign level = sync[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl: captures operands/select from debounced buttons and issues one ALU op via valid/ready.
// ALU_IN_DEBOUNCE_EN enables real debounce counters; undefined gives a 3-cycle fast-sim press path.
module alu_input_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push1,
    input  logic              push2,
    input  logic              push3,
    input  logic [OPND_W-1:0] no,
    output logic [OPND_W-1:0] a_out,
    output logic [OPND_W-1:0] b_out,
    output logic [1:0]        sel_out,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              err
);

    localparam int NUM_BTN = 3;

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] press;
    // Debounced levels are exported by the button block for board debug; unused here.
    logic [NUM_BTN-1:0] btn_lvl_unused;

    assign raw_btn = {push3, push2, push1};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_btn[i]),
            .press(press[i]),
            .level(btn_lvl_unused[i])
        );
    end

    logic [1:0][OPND_W-1:0] no_sync;
    logic [OPND_W-1:0]      no_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            no_sync <= '0;
        end else begin
            no_sync <= {no_sync[0], no};
        end
    end

    assign no_s = no_sync[1];

    alu_state_e        state;
    logic [OPND_W-1:0] a_reg;
    logic [OPND_W-1:0] b_reg;
    logic              a_ok;
    logic              b_ok;
    logic              err_q;
    alu_op_t           op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
            a_reg <= '0;
            b_reg <= '0;
            a_ok  <= 1'b0;
            b_ok  <= 1'b0;
            err_q <= 1'b0;
            op_q  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (press[0]) begin
                        a_reg <= no_s;
                        a_ok  <= 1'b1;
                    end
                    // push1 outranks push2, both outrank push3; losers only flag err.
                    if (press[1]) begin
                        if (press[0]) begin
                            err_q <= 1'b1;
                        end else begin
                            b_reg <= no_s;
                            b_ok  <= 1'b1;
                        end
                    end
                    if (press[2]) begin
                        if (press[0] || press[1] || !(a_ok && b_ok)) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q  <= '{a: a_reg, b: b_reg, sel: alu_sel_e'(no_s[1:0])};
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (|press) begin
                        err_q <= 1'b1;
                    end
                    if (op_ready) begin
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign a_out    = op_q.a;
    assign b_out    = op_q.b;
    assign sel_out  = op_q.sel;
    assign op_valid = (state == ISSUE);
    assign err      = err_q;

endmodule
